traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker on the receiving end of the traffic-light controller outputs. It samples the `ns_light`/`ew_light` one-hot pairs every cycle and tracks the current phase. It checks phase ordering and per-phase dwell time, and reports illegal light patterns, out-of-order phases and dwell violations as single-cycle error pulses plus a sticky summary flag. It sits beside the controller, or at the lamp-driver boundary, and never drives the lights.

## Interface
- `GREEN_CYCLES`, default 3: required dwell of a GO phase, in samples.
- `YELLOW_CYCLES`, default 2: required dwell of a WARN phase, in samples.
- `CNT_W`, default 4: width of the dwell counter; it saturates at 2^CNT_W-1.
- `clk`  in  1: single clock; everything is sampled and updated on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ns_light`  in  3: observed north-south lamp, {R,Y,G}; 100=RED, 010=YELLOW, 001=GREEN.
- `ew_light`  in  3: observed east-west lamp, same encoding.
- `clr_err`  in  1: synchronous clear of `err_sticky`.
- `phase`  out  2: tracked phase; 00 NS_GO, 01 NS_WARN, 10 EW_GO, 11 EW_WARN.
- `locked`  out  1: the monitor is synchronised to the sequence.
- `err_illegal`  out  1: one-cycle pulse when the sampled pair is not one of the four legal phases.
- `err_sequence`  out  1: one-cycle pulse when a legal phase follows a phase that is not its predecessor.
- `err_timing`  out  1: one-cycle pulse when a dwell is too long or too short.
- `err_sticky`  out  1: OR of all error pulses, held until `clr_err`.
- `cycle_count`  out  8: number of complete NS->EW->NS cycles observed while locked; wraps 255->0.

## Operation
- Legal pairs (ns, ew):
  - NS_GO = (001, 100)
  - NS_WARN = (010, 100)
  - EW_GO = (100, 001)
  - EW_WARN = (100, 010)
- Every other pair is illegal. This includes non-one-hot values, both lamps RED, and both lamps non-RED.
- Successor ring: NS_GO -> NS_WARN -> EW_GO -> EW_WARN -> NS_GO.
- Required dwell: GREEN_CYCLES for the GO phases, YELLOW_CYCLES for the WARN phases.
- Internal dwell counter `run_len` holds the number of consecutive samples of the current phase, including the entry sample.
- Per-edge rules, evaluated on the sampled pair P:
  - **P illegal:** pulse `err_illegal`; `locked` <= 0; `phase` and `run_len` are held.
  - **P legal, equal to `phase`:** `run_len` increments, saturating. If `locked` and the pre-increment `run_len` == required dwell, pulse `err_timing`. This fires exactly once per over-long phase.
  - **P legal, successor of `phase`:**
    - `phase` <= P; `run_len` <= 1.
    - If `locked` and the old `run_len` < required dwell of the old phase, pulse `err_timing`.
    - If not locked, `locked` <= 1 and no check is made, because the first dwell is of unknown length.
    - If the transition is EW_WARN -> NS_GO and `locked` was already 1, `cycle_count` increments.
  - **P legal, not successor and not equal:**
    - `phase` <= P; `run_len` <= 1.
    - If `locked`, pulse `err_sequence`; `locked` stays 1.
    - No dwell check is made on the abandoned phase.
    - If not locked, P is adopted silently and `locked` stays 0. Lock requires a successor transition.
- `err_sticky` is set by any error pulse and cleared by `clr_err`. If an error and `clr_err` occur in the same cycle, the error wins and `err_sticky` stays 1.
- At most one of `err_illegal`/`err_sequence`/`err_timing` pulses per cycle.

## Timing
- All outputs are registered. An error pulse is high for the one cycle following the edge that sampled the offending pair.
- No input pipeline; detection latency is 1 cycle.
- Reset values, asynchronous on `rst_n` low:
  - `phase` = NS_GO
  - `run_len` = 0
  - `locked` = 0
  - all error outputs = 0
  - `cycle_count` = 0
- Reset mid-phase discards all history; the first edge after `rst_n` rises is treated as a fresh sample.
- With defaults, a conforming sequence has a 10-cycle period.
- `run_len` saturation prevents wrap. An input stuck in one phase forever yields exactly one `err_timing`.

## Test plan
- **Conforming run:** reset, then drive 30 samples NS_GO×3, NS_WARN×2, EW_GO×3, EW_WARN×2, repeating.
  - `locked` rises after the edge at sample 4.
  - `cycle_count` is 2 after sample 30.
  - No error pulses; `err_sticky` = 0.
- **Long green:** after lock, hold EW_GO for 4 samples.
  - `err_timing` pulses once, following the 4th sample.
  - No pulse at the exit to EW_WARN.
- **Short yellow:** after lock, NS_WARN for 1 sample, then EW_GO.
  - `err_timing` pulses following the EW_GO sample.
  - `phase` = 10; `locked` = 1.
- **Skip:** after lock, NS_GO×3 then EW_GO.
  - `err_sequence` = 1 for one cycle; `err_timing` = 0.
  - `locked` stays 1; `phase` = 10.
- **Illegal pair:** drive ns=001, ew=001.
  - `err_illegal` pulses; `locked` = 0.
  - `err_sticky` stays 1 until `clr_err`. With `clr_err` and a new error in the same cycle, `err_sticky` stays 1.
- **Reset mid-operation:** pull `rst_n` low during EW_GO.
  - All outputs are at reset values immediately, without waiting for a clock edge.
  - The next run relocks exactly as in the conforming run.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Lamp observation and monitor status bundle between a light source and traffic_light_monitor.
interface traffic_light_monitor_if;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       clr_err;
  logic [1:0] phase;
  logic       locked;
  logic       err_illegal;
  logic       err_sequence;
  logic       err_timing;
  logic       err_sticky;
  logic [7:0] cycle_count;

  modport master (
    output ns_light, ew_light, clr_err,
    input  phase, locked, err_illegal, err_sequence, err_timing, err_sticky, cycle_count
  );

  modport slave (
    input  ns_light, ew_light, clr_err,
    output phase, locked, err_illegal, err_sequence, err_timing, err_sticky, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker of traffic-light phase order and dwell time; never drives the lamps.
// Reports illegal patterns, skipped phases and dwell violations as pulses plus a sticky flag.
module traffic_light_monitor #(
  parameter int unsigned GREEN_CYCLES  = 3,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  traffic_light_monitor_if.slave mon
);

  localparam int unsigned CYC_W = 8;
  localparam logic [CNT_W-1:0] GREEN_DWELL  = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] YELLOW_DWELL = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] RUN_MAX      = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    NS_GO   = 2'b00,
    NS_WARN = 2'b01,
    EW_GO   = 2'b10,
    EW_WARN = 2'b11
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             locked_q, locked_d;
  logic             err_ill_q, err_ill_d;
  logic             err_seq_q, err_seq_d;
  logic             err_tim_q, err_tim_d;
  logic             sticky_q, sticky_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic             legal_c;
  phase_e           obs_c;
  phase_e           succ_c;
  logic [CNT_W-1:0] req_c;

  // Map the sampled lamp pair onto a phase; anything else is illegal.
  always_comb begin
    legal_c = 1'b1;
    obs_c   = NS_GO;
    case ({mon.ns_light, mon.ew_light})
      6'b001_100: obs_c = NS_GO;
      6'b010_100: obs_c = NS_WARN;
      6'b100_001: obs_c = EW_GO;
      6'b100_010: obs_c = EW_WARN;
      default:    legal_c = 1'b0;
    endcase
  end

  assign succ_c = phase_e'(2'(phase_q + 2'd1));
  assign req_c  = phase_q[0] ? YELLOW_DWELL : GREEN_DWELL;

  always_comb begin
    phase_d   = phase_q;
    run_len_d = run_len_q;
    locked_d  = locked_q;
    err_ill_d = 1'b0;
    err_seq_d = 1'b0;
    err_tim_d = 1'b0;
    cyc_d     = cyc_q;

    if (!legal_c) begin
      err_ill_d = 1'b1;
      locked_d  = 1'b0;
    end else if (obs_c == phase_q) begin
      // Pre-increment compare fires exactly once per over-long dwell.
      if (run_len_q != RUN_MAX) run_len_d = run_len_q + CNT_W'(1);
      if (locked_q && (run_len_q == req_c)) err_tim_d = 1'b1;
    end else if (obs_c == succ_c) begin
      phase_d   = obs_c;
      run_len_d = CNT_W'(1);
      if (locked_q) begin
        if (run_len_q < req_c) err_tim_d = 1'b1;
        if (phase_q == EW_WARN) cyc_d = cyc_q + CYC_W'(1);
      end else begin
        locked_d = 1'b1;
      end
    end else begin
      phase_d   = obs_c;
      run_len_d = CNT_W'(1);
      if (locked_q) err_seq_d = 1'b1;
    end

    // A new error beats a simultaneous clear.
    sticky_d = sticky_q;
    if (err_ill_d || err_seq_d || err_tim_d) sticky_d = 1'b1;
    else if (mon.clr_err)                    sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= NS_GO;
      run_len_q <= '0;
      locked_q  <= 1'b0;
      err_ill_q <= 1'b0;
      err_seq_q <= 1'b0;
      err_tim_q <= 1'b0;
      sticky_q  <= 1'b0;
      cyc_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      run_len_q <= run_len_d;
      locked_q  <= locked_d;
      err_ill_q <= err_ill_d;
      err_seq_q <= err_seq_d;
      err_tim_q <= err_tim_d;
      sticky_q  <= sticky_d;
      cyc_q     <= cyc_d;
    end
  end

  assign mon.phase        = phase_q;
  assign mon.locked       = locked_q;
  assign mon.err_illegal  = err_ill_q;
  assign mon.err_sequence = err_seq_q;
  assign mon.err_timing   = err_tim_q;
  assign mon.err_sticky   = sticky_q;
  assign mon.cycle_count  = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scoreboard bench for traffic_light_monitor with default dwell parameters.
module tb_traffic_light_monitor;

  typedef struct packed {
    logic [1:0] phase;
    logic       locked;
    logic       ill;
    logic       seq;
    logic       tim;
    logic       sticky;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  traffic_light_monitor_if mon ();

  traffic_light_monitor #(
    .GREEN_CYCLES (3),
    .YELLOW_CYCLES(2),
    .CNT_W        (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (mon)
  );

  function automatic exp_t mk(input logic [1:0] ph, input logic lk, input logic il,
                              input logic sq, input logic tm, input logic st,
                              input logic [7:0] cn);
    exp_t e;
    e.phase = ph; e.locked = lk; e.ill = il; e.seq = sq; e.tim = tm; e.sticky = st; e.cnt = cn;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.phase  = mon.phase;
    o.locked = mon.locked;
    o.ill    = mon.err_illegal;
    o.seq    = mon.err_sequence;
    o.tim    = mon.err_timing;
    o.sticky = mon.err_sticky;
    o.cnt    = mon.cycle_count;
    return o;
  endfunction

  function automatic logic [5:0] pair_of(input logic [1:0] ph);
    case (ph)
      2'd0:    return 6'b001_100;
      2'd1:    return 6'b010_100;
      2'd2:    return 6'b100_001;
      default: return 6'b100_010;
    endcase
  endfunction

  // Drive one sample, queue what must appear after the edge, then compare.
  task automatic step_raw(input string tag, input logic [5:0] pair, input logic clr, input exp_t e);
    exp_t got, want;
    @(negedge clk);
    mon.ns_light = pair[5:3];
    mon.ew_light = pair[2:0];
    mon.clr_err  = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = observed();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      want = sb.pop_front();
      assert (got === want) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
    end
  endtask

  task automatic step(input string tag, input logic [1:0] ph, input logic clr, input exp_t e);
    step_raw(tag, pair_of(ph), clr, e);
  endtask

  task automatic check_reset(input string tag);
    exp_t got;
    got = observed();
    total++;
    assert (got === mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    end
  endtask

  // Thirty conforming samples straight out of reset.
  task automatic run_conform(input string tag);
    for (int i = 1; i <= 30; i++) begin
      int k;
      logic [1:0] ph;
      logic [7:0] cn;
      k  = (i - 1) % 10;
      ph = (k < 3) ? 2'd0 : (k < 5) ? 2'd1 : (k < 8) ? 2'd2 : 2'd3;
      cn = (i >= 21) ? 8'd2 : (i >= 11) ? 8'd1 : 8'd0;
      step(tag, ph, 1'b0, mk(ph, (i >= 4), 1'b0, 1'b0, 1'b0, 1'b0, cn));
    end
  endtask

  initial begin
    mon.ns_light = 3'b001;
    mon.ew_light = 3'b100;
    mon.clr_err  = 1'b0;
    rst_n        = 1'b0;
    #2;
    check_reset("reset_initial");
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_conform("conform");

    // Long green: fourth EW_GO sample over-runs, exit is silent.
    step("lg_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ns_warn", 2'd1, 1'b0, mk(2'd1, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ns_warn", 2'd1, 1'b0, mk(2'd1, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ew_go1", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ew_go2", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ew_go3", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 0, 0, 8'd3));
    step("lg_ew_go4", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 1, 1, 8'd3));
    step("lg_exit", 2'd3, 1'b0, mk(2'd3, 1, 0, 0, 0, 1, 8'd3));
    step("lg_ew_warn", 2'd3, 1'b0, mk(2'd3, 1, 0, 0, 0, 1, 8'd3));
    step("lg_clear", 2'd0, 1'b1, mk(2'd0, 1, 0, 0, 0, 0, 8'd4));

    // Short yellow.
    step("sy_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd4));
    step("sy_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd4));
    step("sy_ns_warn", 2'd1, 1'b0, mk(2'd1, 1, 0, 0, 0, 0, 8'd4));
    step("sy_ew_go", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 1, 1, 8'd4));
    step("sy_clear", 2'd2, 1'b1, mk(2'd2, 1, 0, 0, 0, 0, 8'd4));
    step("sy_ew_go", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 0, 0, 8'd4));
    step("sy_ew_warn", 2'd3, 1'b0, mk(2'd3, 1, 0, 0, 0, 0, 8'd4));
    step("sy_ew_warn", 2'd3, 1'b0, mk(2'd3, 1, 0, 0, 0, 0, 8'd4));

    // Skip from NS_GO straight to EW_GO.
    step("sk_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd5));
    step("sk_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd5));
    step("sk_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 0, 8'd5));
    step("sk_ew_go", 2'd2, 1'b0, mk(2'd2, 1, 0, 1, 0, 1, 8'd5));
    step("sk_clear", 2'd2, 1'b1, mk(2'd2, 1, 0, 0, 0, 0, 8'd5));

    // Illegal pairs, sticky behaviour and relock.
    step_raw("il_both_green", 6'b001_001, 1'b0, mk(2'd2, 0, 1, 0, 0, 1, 8'd5));
    step("il_after", 2'd2, 1'b0, mk(2'd2, 0, 0, 0, 0, 1, 8'd5));
    step_raw("il_clr_vs_err", 6'b111_100, 1'b1, mk(2'd2, 0, 1, 0, 0, 1, 8'd5));
    step("il_clear", 2'd2, 1'b1, mk(2'd2, 0, 0, 0, 0, 0, 8'd5));
    step("il_relock", 2'd3, 1'b0, mk(2'd3, 1, 0, 0, 0, 0, 8'd5));

    // Stuck phase: one timing pulse only, dwell counter must not wrap.
    for (int j = 0; j < 20; j++) begin
      step("stuck_ew_warn", 2'd3, 1'b0, mk(2'd3, 1, 0, 0, (j == 1), (j >= 1), 8'd5));
    end

    // Reset asserted mid EW_GO.
    step("rs_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 1, 8'd6));
    step("rs_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 1, 8'd6));
    step("rs_ns_go", 2'd0, 1'b0, mk(2'd0, 1, 0, 0, 0, 1, 8'd6));
    step("rs_ns_warn", 2'd1, 1'b0, mk(2'd1, 1, 0, 0, 0, 1, 8'd6));
    step("rs_ns_warn", 2'd1, 1'b0, mk(2'd1, 1, 0, 0, 0, 1, 8'd6));
    step("rs_ew_go", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 0, 1, 8'd6));
    step("rs_ew_go", 2'd2, 1'b0, mk(2'd2, 1, 0, 0, 0, 1, 8'd6));
    #2 rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_conform("reconform");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
